// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient loader control path.
// Pure declarations; no timing or flow control of its own.
package fir_ctrl_pkg;

  localparam int DEF_N_TAPS = 4;
  localparam int DEF_COEF_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2,
    ACK   = 2'd3
  } fsm_state_e;

  // The commit command sits at the first address past the last tap.
  function automatic int commit_addr(input int n_taps);
    return n_taps;
  endfunction

endpackage

// File: rtl/two_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk edges; no backpressure, the level is simply resampled each cycle.
module two_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Host-to-filter coefficient loader: 4-phase req/ack writes into a shadow bank, atomic commit to the active bank.
// Latency: ack rises 5 edges after req rise, falls 3 edges after req fall; host is held off by withholding ack.
module fir_coeff_loader
  import fir_ctrl_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_req,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [COEF_W-1:0]        host_data,
  output logic                     host_ack,
  output logic [N_TAPS*COEF_W-1:0] coef_flat,
  output logic                     coef_update,
  output logic                     busy,
  output logic                     cmd_err
);

  localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(commit_addr(N_TAPS));

  logic              req_s;
  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [COEF_W-1:0] data_q;
  logic [COEF_W-1:0] shadow_q [N_TAPS];
  logic [COEF_W-1:0] active_q [N_TAPS];
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              upd_q;
  logic              err_q;
  logic              capture, wr_en, commit_en, bad_cmd;

  two_bit_sync u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (host_req),
    .q_o (req_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_s) state_d = LATCH;
      LATCH:   state_d = EXEC;
      EXEC:    state_d = ACK;
      ACK:     if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture   = (state_q == LATCH);
    wr_en     = 1'b0;
    commit_en = 1'b0;
    bad_cmd   = 1'b0;
    if (state_q == EXEC) begin
      if (addr_q < COMMIT_ADDR) begin
        wr_en = 1'b1;
      end else if (addr_q == COMMIT_ADDR) begin
        commit_en = 1'b1;
      end else begin
        bad_cmd = 1'b1;
      end
    end
    ack_d  = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  // Host address/data are only sampled once req_s proves they have been stable for two edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (capture) begin
      addr_q <= host_addr;
      data_q <= host_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (wr_en && (addr_q == ADDR_W'(i))) shadow_q[i] <= data_q;
        if (commit_en) active_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      upd_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      busy_q <= busy_d;
      upd_q  <= commit_en;
      if (commit_en) begin
        err_q <= 1'b0;
      end else if (bad_cmd) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    coef_flat = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      coef_flat[i*COEF_W +: COEF_W] = active_q[i];
    end
  end

  assign host_ack    = ack_q;
  assign busy        = busy_q;
  assign coef_update = upd_q;
  assign cmd_err     = err_q;

endmodule
